// File: rtl/mem_arb.sv
// Two-master memory arbiter with a bounded hold per grant and an in-order
// read-owner tag FIFO that routes returning read data to the issuing master.
module mem_arb #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_HOLD    = 8,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdataready,
    output logic                  m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdataready,
    output logic                  m1_waitrequest,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [BE_WIDTH-1:0]   s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata,
    input  logic                  s_readdataready,
    input  logic                  s_waitrequest,
    output logic [1:0]            owner,
    output logic                  protocol_err
);

    localparam int HOLD_W = ($clog2(MAX_HOLD) > 3) ? $clog2(MAX_HOLD) : 3;
    localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(OUTSTANDING + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

    state_t                 state_q, state_d;
    logic                   last_gnt_q, last_gnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUTSTANDING-1:0] tag_q;
    logic                   err_q, err_d;

    logic req0, req1, me_req, oth_req, me_id;
    logic fifo_empty, blocked, accept, push, pop, expire, head_tag;
    state_t oth_state;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign req0       = m0_read;
    assign req1       = m1_read | m1_write;
    assign fifo_empty = (cnt_q == '0);
    assign blocked    = (cnt_q == CNT_FULL) & ~s_readdataready;
    assign head_tag   = tag_q[rd_ptr_q];
    assign pop        = s_readdataready & ~fifo_empty;
    assign accept     = (s_read | s_write) & ~s_waitrequest;
    assign push       = accept & s_read;

    // Command mux; a simultaneous read+write from m1 is forwarded as a write.
    always_comb begin
        s_address      = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            GNT0: begin
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~blocked;
                m0_waitrequest = s_waitrequest | (m0_read & blocked);
            end
            GNT1: begin
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write & ~blocked;
                m1_waitrequest = s_waitrequest | (m1_read & ~m1_write & blocked);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        last_gnt_d = last_gnt_q;
        me_req     = (state_q == GNT1) ? req1 : req0;
        oth_req    = (state_q == GNT1) ? req0 : req1;
        me_id      = (state_q == GNT1);
        oth_state  = (state_q == GNT1) ? GNT0 : GNT1;
        expire     = accept & (hold_q == HOLD_LAST);
        if (state_q == IDLE) begin
            if (req0 && req1)
                state_d = last_gnt_q ? GNT0 : GNT1;
            else if (req0)
                state_d = GNT0;
            else if (req1)
                state_d = GNT1;
        end else if (!me_req || expire) begin
            if (oth_req) begin
                state_d    = oth_state;
                last_gnt_d = me_id;
            end else if (me_req) begin
                hold_d = '0;
            end else begin
                state_d    = IDLE;
                last_gnt_d = me_id;
            end
        end else if (accept) begin
            hold_d = hold_q + 1'b1;
        end
        if (state_d != state_q)
            hold_d = '0;
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
        err_d = err_q | (s_readdataready & fifo_empty) | (m1_read & m1_write);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Tag storage is only meaningful below cnt_q, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push)
            tag_q[wr_ptr_q] <= (state_q == GNT1);
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdataready = pop & ~head_tag;
    assign m1_readdataready = pop & head_tag;
    assign owner            = state_q;
    assign protocol_err     = err_q;

endmodule
